// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 program loader: FSM states, the hold
// instruction fed to the core while parked, and default geometry.
package td4_pkg;

  localparam int TD4_DEPTH  = 16;
  localparam int TD4_ADDR_W = 4;
  localparam int TD4_DATA_W = 8;

  // JMP 0 with no carry condition: keeps the CPU program counter at 0.
  localparam logic [7:0] TD4_HOLD_INSTR = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/td4_prog_loader_if.sv
// Byte-serial valid/ready load port of the TD4 program loader.
interface td4_prog_loader_if #(
  parameter int DATA_W = 8
);

  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_data, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_data, output wr_ready);

endinterface

// File: rtl/td4_prog_array.sv
// DEPTH x DATA_W program register file: one synchronous write port,
// one asynchronous read port, synchronous clear on rst.
module td4_prog_array #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: non-blocking assignments in clocked blocks so every register
  // samples pre-edge values regardless of process ordering.
  // NOTE: the array is deliberately cleared on reset, so a partial load
  // never exposes a stale image; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read lets the CPU fetch within its own cycle.
  assign rdata = mem[raddr];

endmodule

// File: rtl/td4_prog_loader.sv
// TD4 program store and loader: byte-serial load, then serves mem[addr] in RUN.
// Optional image checksum enabled by `define TD4_LOADER_CHECKSUM_EN.
module td4_prog_loader
  import td4_pkg::*;
#(
  parameter int DEPTH  = TD4_DEPTH,
  parameter int ADDR_W = TD4_ADDR_W,
  parameter int DATA_W = TD4_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_req,
  input  logic               start,
  td4_prog_loader_if.slave   wr,
  input  logic [ADDR_W-1:0]  addr,
  output logic [DATA_W-1:0]  instr,
  output logic               cpu_run,
  output logic               load_done,
  output logic [7:0]         checksum
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic              done_q;
  logic              accept;
  logic              last_byte;
  logic [DATA_W-1:0] rd_data;

  // A byte offered together with load_req is dropped by the restart.
  assign wr.wr_ready = (state_q == ST_LOAD);
  assign accept      = wr.wr_ready && wr.wr_valid && !load_req;
  assign last_byte   = accept && (ptr_q == LAST_PTR);

  // NOTE: next state defaults to the current state before the case, so no
  // path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_req)   state_d = ST_LOAD;
        else if (start) state_d = ST_RUN;
      end
      ST_LOAD: begin
        if (load_req)                state_d = ST_LOAD;
        else if (last_byte || start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (load_req) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_byte;
      if (load_req)    ptr_q <= '0;
      else if (accept) ptr_q <= ptr_q + ADDR_W'(1);
    end
  end

  td4_prog_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr (ptr_q),
    .wdata (wr.wr_data),
    .raddr (addr),
    .rdata (rd_data)
  );

  assign cpu_run   = (state_q == ST_RUN);
  assign instr     = cpu_run ? rd_data : DATA_W'(TD4_HOLD_INSTR);
  assign load_done = done_q;

`ifdef TD4_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;

  // Sum restarts on every entry into LOAD and holds through RUN.
  always_ff @(posedge clk) begin
    if (rst)           sum_q <= 8'h00;
    else if (load_req) sum_q <= 8'h00;
    else if (accept)   sum_q <= sum_q + 8'(wr.wr_data);
  end

  assign checksum = sum_q;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: doc/td4_prog_loader.md
# td4_prog_loader

Program store and loader for the TD4 CPU, sitting directly upstream of the CPU core's 8-bit instruction input. Holds a 16 × 8 program image written byte-serially over a valid/ready port, then serves the instruction addressed by the CPU's 4-bit program counter. While no program is running, it feeds the core a hold instruction so the CPU parks at address 0.

## Interface
Parameters:
- `DEPTH`, 16: number of program bytes. Must equal 2^`ADDR_W`.
- `ADDR_W`, 4: program counter width.
- `DATA_W`, 8: instruction width. Bits [7:4] are the opcode and bits [3:0] are the immediate.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_req`  in  1  start or restart a program load.
- `start`  in  1  begin execution.
- `wr_valid`  in  1  a load byte is present.
- `wr_data`  in  `DATA_W`  load byte.
- `wr_ready`  out  1  loader accepts a byte this cycle.
- `addr`  in  `ADDR_W`  CPU program counter.
- `instr`  out  `DATA_W`  instruction to the CPU core.
- `cpu_run`  out  1  high in RUN; gates the CPU.
- `load_done`  out  1  one-cycle pulse when a full image has been loaded.
- `checksum`  out  8  image checksum (see Configuration).

## Operation
States: IDLE, LOAD, RUN.

Reset values:
- state = IDLE.
- all memory bytes = 0x00.
- write pointer = 0.
- `wr_ready` = 0, `cpu_run` = 0, `load_done` = 0, `checksum` = 0x00.

Transitions, evaluated at the rising edge:
- **IDLE:**
  - `load_req` → LOAD, pointer cleared to 0.
  - else `start` → RUN.
  - `load_req` has priority over `start`.
- **LOAD:**
  - `wr_ready` = 1.
  - On `wr_valid` && `wr_ready`: write `mem[ptr]` = `wr_data`, then `ptr` = `ptr` + 1.
  - Accepting the byte at `ptr` = `DEPTH`-1 → RUN, and `load_done` pulses in the following cycle.
  - `load_req` → restart: pointer = 0, any byte offered that cycle is discarded, and the bytes already written are kept until overwritten.
  - `start` (with no `load_req`) → RUN, abandoning the partial load. `load_done` does not pulse.
- **RUN:**
  - `load_req` → LOAD, pointer = 0.
  - `start` is ignored.

Read path:
- RUN: `instr` = `mem[addr]`, asynchronous read, so the CPU fetches within its own cycle.
- IDLE and LOAD: `instr` = 0xF0, i.e. JMP 0 with no carry condition. This holds the CPU's program counter at 0.

Other rules:
- The pointer never wraps within a load; reaching `DEPTH` always exits LOAD.
- `wr_data` is stored unmodified. The loader does not validate opcodes.

## Timing
- Write latency: a byte accepted at edge N is readable in RUN from edge N onward.
- `cpu_run` and the switch of `instr` from 0xF0 to `mem[addr]` both take effect in the cycle after the edge that enters RUN.
- The CPU core is reset-released in the same cycle as `cpu_run`. The first fetched address is therefore 0.
- `rst` asserted mid-load or mid-run: at the next edge, all state and memory return to their reset values.
- `wr_ready` is a function of state only. It does not depend combinationally on `wr_valid`.

## Configuration
Macro: `TD4_LOADER_CHECKSUM_EN`.
- **Defined:**
  - `checksum` = 8-bit sum, mod 256, of all bytes accepted since the last entry into LOAD.
  - The sum clears on entry to LOAD, including a restart.
  - The value holds through RUN.
- **Undefined:**
  - `checksum` is tied to 0x00.
  - No adder or register is generated.

## Structure
- Shared package `td4_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_LOAD`, `ST_RUN`);
  - `TD4_HOLD_INSTR` = 8'hF0;
  - the default `DEPTH`, `ADDR_W` and `DATA_W`.
- Sub-module `td4_prog_array`: a `DEPTH` × `DATA_W` register file with one synchronous write port, one asynchronous read port, and synchronous clear on `rst`.
- The FSM, pointer and checksum live in the top module.

## Test plan
- **Reset:** `rst` high for 2 cycles → `instr` = 0xF0, `cpu_run` = 0, `wr_ready` = 0, `checksum` = 0x00.
- **Full load:**
  - Stimulus: `load_req`, then 16 bytes 0x30..0x3F with `wr_valid` held high.
  - Required response: `load_done` pulses once, one cycle after the 16th byte; `cpu_run` = 1; `instr` at `addr` = 5 is 0x35; `checksum` = 0x78 when the macro is defined.
- **Backpressure and gaps:** load with `wr_valid` toggling every cycle → exactly 16 writes occur, and the image matches the bytes offered.
- **Restart mid-load:**
  - Stimulus: after 6 bytes, `load_req` together with `wr_valid` and byte 0xAA.
  - Required response: 0xAA is discarded, the pointer returns to 0, and 16 more bytes are needed before `load_done`.
- **Abort and start:**
  - Stimulus: in LOAD after 3 bytes (0x11, 0x22, 0x33), assert `start`.
  - Required response: RUN is entered; `mem[0..2]` = 0x11, 0x22, 0x33; `mem[3..15]` = 0x00; no `load_done`.
- **Reset in RUN:** after a full load, `rst` → `cpu_run` = 0, `instr` = 0xF0; after a subsequent `start`, `instr` at `addr` = 5 reads 0x00.
